// File: rtl/product_accumulator_if.sv
// Handshake bundle between a product source, the accumulator
// and the result consumer.
interface product_accumulator_if #(
   parameter int PROD_W = 64,
   parameter int CNT_W  = 8
);
   logic              start;
   logic [CNT_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] acc_out;
   logic              overflow;
   logic              busy;

   modport master (
      output start, len, in_valid, product, out_ready,
      input  in_ready, out_valid, acc_out, overflow, busy
   );

   modport slave (
      input  start, len, in_valid, product, out_ready,
      output in_ready, out_valid, acc_out, overflow, busy
   );
endinterface

// File: rtl/product_accumulator.sv
// Saturating signed accumulator of a fixed-length job of
// multiplier products, with a held result handshake.
module product_accumulator #(
   parameter int PROD_W = 64,
   parameter int CNT_W  = 8
) (
   input  logic clk,
   input  logic rst,
   product_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [PROD_W-1:0] MAXV =
      {1'b0, {(PROD_W-1){1'b1}}};
   localparam logic [PROD_W-1:0] MINV =
      {1'b1, {(PROD_W-1){1'b0}}};

   state_t            state;
   state_t            state_n;
   logic [PROD_W-1:0] acc;
   logic              ovf;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  len_q;
   logic [PROD_W:0]   sum;
   logic              load;
   logic              xfer;
   logic              last;
   logic              pos_ovf;
   logic              neg_ovf;

   // Sign-extended sum; the top two bits disagree on overflow.
   assign sum = {acc[PROD_W-1], acc}
              + {bus.product[PROD_W-1], bus.product};
   assign pos_ovf = ~sum[PROD_W] &  sum[PROD_W-1];
   assign neg_ovf =  sum[PROD_W] & ~sum[PROD_W-1];
   assign cnt_nxt = cnt + 1'b1;
   assign last    = (cnt_nxt == len_q);

   assign bus.acc_out  = acc;
   assign bus.overflow = ovf;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state and handshake outputs, decoded from state.
   always_comb begin
      state_n       = state;
      load          = 1'b0;
      xfer          = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      unique case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               load    = 1'b1;
               state_n = (bus.len != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               xfer = 1'b1;
               if (last) state_n = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Accumulator, sticky overflow and transfer count.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         len_q <= '0;
      end else if (load) begin
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         len_q <= bus.len;
      end else if (xfer) begin
         cnt <= cnt_nxt;
         if (pos_ovf) begin
            acc <= MAXV;
            ovf <= 1'b1;
         end else if (neg_ovf) begin
            acc <= MINV;
            ovf <= 1'b1;
         end else begin
            acc <= sum[PROD_W-1:0];
         end
      end
   end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 32x32 signed Booth multiplier's 64-bit product. Sums a programmed number of signed products into a saturating 64-bit accumulator using a valid/ready handshake, then presents the total on a held result interface. This block is the accumulate half of the multiply-accumulate path in the multiplier subsystem.

Parameters:
PROD_W, 64, product and accumulator width in bits; signed two's complement.
CNT_W, 8, width of the job-length field; maximum job length is 2^CNT_W-1 products.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  job request; sampled only in IDLE
len  input  CNT_W  number of products in the job; latched on accepted start
in_valid  input  1  product is valid
in_ready  output  1  block will accept the product this cycle
product  input  PROD_W  signed product from the multiplier
out_valid  output  1  result is valid
out_ready  input  1  downstream accepts the result
acc_out  output  PROD_W  signed accumulated result
overflow  output  1  sticky saturation flag for the current job
busy  output  1  high whenever the state is not IDLE

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, acc_out=0, overflow=0, in_ready=0, out_valid=0, busy=0, internal count=0.
- rst has priority over every other input. Asserting rst mid-job abandons the job with no result emitted.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch len, clear acc_out, overflow and count.
  - Next state is ACCUM if len!=0, otherwise DONE with acc_out=0.
- ACCUM:
  - in_ready=1, combinational from state only.
  - A transfer occurs when in_valid && in_ready.
  - On each transfer: compute sum = acc_out + product, sign-extended to PROD_W+1 bits, and increment count.
  - Positive overflow (sum exceeds 2^(PROD_W-1)-1): acc_out clamps to 0x7FFF_FFFF_FFFF_FFFF and overflow is set.
  - Negative overflow (sum below -2^(PROD_W-1)): acc_out clamps to 0x8000_0000_0000_0000 and overflow is set.
  - Otherwise acc_out takes the low PROD_W bits of sum.
  - overflow is sticky until the next accepted start or rst.
  - Later products add to the clamped value; the accumulator does not wrap.
  - When the transfer makes count equal the latched len, the next state is DONE.
  - Cycles with in_valid=0 leave all state unchanged.
- DONE:
  - out_valid=1, in_ready=0. acc_out and overflow are held stable.
  - On out_valid && out_ready, the next state is IDLE and out_valid drops in the following cycle.
  - acc_out keeps its final value in IDLE until the next accepted start.
- Latency: the final input transfer in cycle t gives out_valid=1 in cycle t+1. A start with len=0 gives out_valid=1 one cycle after the start.
- start is ignored while busy. A start in the same cycle as the DONE handshake is ignored; start is accepted only from IDLE.
- product is ignored outside ACCUM even if in_valid=1.
- Throughput: one product per cycle in ACCUM. A back-to-back job costs 2 idle cycles: the DONE handshake, then the IDLE start.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with random inputs -> all outputs 0, state IDLE; in_valid=1 in IDLE -> in_ready stays 0.
- Basic job: start, len=3, products 5, -2, 10 on consecutive cycles -> out_valid the cycle after the third transfer, acc_out=13, overflow=0. out_ready=1 -> busy drops the next cycle.
- Zero length: start, len=0 -> out_valid=1 one cycle later with acc_out=0 and overflow=0; no input transfers occur.
- Positive saturation: len=3, products 0x7FFF_FFFF_FFFF_FFFF, 1, -5 -> after the 2nd transfer acc_out=0x7FFF_FFFF_FFFF_FFFF and overflow=1; final acc_out=0x7FFF_FFFF_FFFF_FFFA, overflow=1. Negative case: len=2, products 0x8000_0000_0000_0000, -1 -> acc_out=0x8000_0000_0000_0000, overflow=1.
- Handshake stress: len=4 with in_valid gaps (pattern 1,0,0,1,1,0,1), products 1, 2, 3, 4 -> acc_out=10. Hold out_ready=0 for 5 cycles -> out_valid and acc_out stay stable. Pulse start during ACCUM and during DONE -> ignored.
- Reset mid-job: len=5, rst after 2 transfers -> next cycle all outputs at reset values. A new start with len=1, product -7 -> acc_out=-7, overflow=0.
